hub_write_ctrl: RTL and testbench
=================================

Name: hub_write_ctrl

Overview:
- Upstream feeder of the hub register memory.
- Accepts the quadlet stream of a received broadcast block-write from a peer board and places each payload quadlet in that board's 32-quadlet slot of hub space.
- Drives the hub memory write port (reg_wen / reg_waddr / reg_wdata).
- Tracks the broadcast sequence number and a per-board "updated in current sequence" bitmask for host readout.

Parameters:
- SLOT_QUADS, 32, quadlets per board slot (power of two; 16 boards x 32 = 512 words = 9-bit hub address).
- MAX_PAYLOAD, 28, payload quadlets accepted per packet; extra quadlets are dropped.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_start  in  1  pulse, first quadlet of a broadcast packet present on rx_data.
- rx_valid  in  1  rx_data holds a valid quadlet (includes the start quadlet).
- rx_data  in  32  received quadlet.
- rx_end  in  1  pulse with or after the last quadlet; packet CRC checked.
- rx_crc_ok  in  1  qualifies rx_end.
- rx_board  in  4  source board id, stable from rx_start to rx_end.
- reg_wen  out  1  hub memory write enable.
- reg_waddr  out  16  {ADDR_HUB, 3'b000, board[3:0], qidx[4:0]}.
- reg_wdata  out  32  write data.
- hub_seq  out  16  current broadcast sequence number.
- hub_upd_mask  out  16  bit b set = board b delivered a good packet in hub_seq.
- hub_ovf  out  1  sticky: a packet exceeded MAX_PAYLOAD.
- hub_ovf_clr  in  1  clears hub_ovf.

Behaviour:
- Reset values: reg_wen=0, reg_waddr=0, reg_wdata=0, hub_seq=0, hub_upd_mask=0, hub_ovf=0. FSM starts in IDLE.
- FSM states and transitions:
  - IDLE: on rx_start & rx_valid, latch rx_board and the header quadlet (seq = rx_data[15:0]), qidx=0, go to PAYLOAD.
  - PAYLOAD: each rx_valid quadlet is written at qidx, then qidx increments. At qidx==MAX_PAYLOAD, further quadlets set hub_ovf and go to DROP. rx_end goes to COMMIT.
  - DROP: ignore quadlets; rx_end goes to COMMIT.
  - COMMIT: one cycle. If rx_crc_ok:
    - If header seq != hub_seq: hub_seq <= header seq, hub_upd_mask <= (1<<board).
    - Else: hub_upd_mask[board] <= 1.
  - COMMIT with a CRC error: clear hub_upd_mask[board]; hub_seq unchanged. Return to IDLE.
- Write latency: registered outputs. A quadlet accepted in cycle N appears on reg_wen/reg_waddr/reg_wdata in cycle N+1. reg_wen is high for exactly one cycle per payload quadlet. No backpressure: one write per cycle maximum, matching the hub memory.
- The header quadlet is not written.
- Boundary conditions:
  - rx_start while not in IDLE: abort the current packet without commit (mask bit of the old board cleared), then restart with the new header the same cycle.
  - rx_end with rx_valid in the same cycle: write the quadlet first, then commit.
  - Zero-payload packet: commit only.
  - qidx does not wrap; overflow is handled via DROP.
  - hub_ovf_clr coinciding with a set event: the set wins.
  - Reset mid-packet: FSM returns to IDLE and the partial packet is not committed. Memory contents are not cleared.

Optional Feature:
- HUB_TIMESTAMP_EN defined:
  - A 32-bit free-running counter on sysclk (reset to 0).
  - In COMMIT with rx_crc_ok, the counter value is written to quadlet SLOT_QUADS-1 of the board's slot. This adds one extra reg_wen cycle, so COMMIT lasts 2 cycles.
  - rx_start during the extra cycle is accepted as in the abort rule.
- Undefined: no counter; quadlet 31 is never written.

Decomposition:
- Shared constants (ADDR_HUB, slot size, FSM state encoding) belong in Constants.v.
- One natural sub-module: hub_seq_tracker, holding hub_seq, hub_upd_mask, and the COMMIT/abort update logic. The FSM and address generation stay in the top.

Test Plan:
- Board 3, header seq=0x0010, 4 payload quadlets A0..A3, CRC ok:
  - Writes at 0x?060..0x?063 (top nibble ADDR_HUB), reg_wen exactly 4 cycles, first write 1 cycle after the first payload quadlet.
  - hub_seq=0x0010, hub_upd_mask=0x0008.
- Board 5 packet with seq=0x0010, then board 5 packet with seq=0x0011:
  - mask goes 0x0028, then 0x0020, with hub_seq=0x0011.
- Board 2 packet with 30 payload quadlets:
  - 28 writes (addr 0x40..0x5B), hub_ovf=1.
  - hub_ovf_clr pulse returns hub_ovf to 0.
- Board 7 packet with rx_crc_ok=0 after bit 7 was already set:
  - Writes still occur, mask bit 7 cleared, hub_seq unchanged.
- rx_start from board 1 mid-way through a board 4 packet:
  - Board 4 bit cleared, board 1 payload written from qidx 0, board 1 committed on its rx_end.
- With HUB_TIMESTAMP_EN, board 0 good packet:
  - Extra write at addr 0x01F carrying the counter value from the COMMIT cycle.
  - Reset asserted mid-packet: reg_wen=0 immediately, no commit.

Source files
------------

// File: rtl/hub_write_ctrl_pkg.sv
// Shared constants for the hub write controller: hub address map, slot geometry and FSM encoding.
package hub_write_ctrl_pkg;

    localparam logic [3:0] ADDR_HUB    = 4'h1;
    localparam int         SLOT_QUADS  = 32;
    localparam int         MAX_PAYLOAD = 28;
    localparam int         QIDX_W      = $clog2(SLOT_QUADS);

    localparam logic [QIDX_W-1:0] QIDX_MAX = QIDX_W'(MAX_PAYLOAD);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PAYLOAD = 3'd1;
    localparam logic [2:0] ST_DROP    = 3'd2;
    localparam logic [2:0] ST_COMMIT  = 3'd3;
    localparam logic [2:0] ST_TSTAMP  = 3'd4;

    function automatic logic [15:0] hub_addr(input logic [3:0] board, input logic [QIDX_W-1:0] qidx);
        return {ADDR_HUB, 3'b000, board, qidx};
    endfunction

endpackage

// File: rtl/hub_write_ctrl_seq_tracker.sv
// Broadcast sequence number and per-board "updated in this sequence" mask, driven by packet commit/abort.
module hub_write_ctrl_seq_tracker (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        commit_i,
    input  logic        abort_i,
    input  logic        crc_ok_i,
    input  logic [3:0]  board_i,
    input  logic [15:0] seq_i,
    output logic [15:0] hub_seq_o,
    output logic [15:0] hub_upd_mask_o
);

    logic [15:0] seq_q, seq_d;
    logic [15:0] mask_q, mask_d;

    always_comb begin
        seq_d  = seq_q;
        mask_d = mask_q;
        if (commit_i && crc_ok_i) begin
            // A new sequence number starts a fresh mask owned by this board alone.
            if (seq_i != seq_q) begin
                seq_d  = seq_i;
                mask_d = 16'd1 << board_i;
            end else begin
                mask_d[board_i] = 1'b1;
            end
        end else if (commit_i || abort_i) begin
            mask_d[board_i] = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            seq_q  <= 16'd0;
            mask_q <= 16'd0;
        end else begin
            seq_q  <= seq_d;
            mask_q <= mask_d;
        end
    end

    assign hub_seq_o      = seq_q;
    assign hub_upd_mask_o = mask_q;

endmodule

// File: rtl/hub_write_ctrl.sv
// Places broadcast block-write payload quadlets into each board's hub slot and tracks sequence state.
// Optional build macro HUB_TIMESTAMP_EN adds a commit timestamp write to the last quadlet of the slot.
module hub_write_ctrl
    import hub_write_ctrl_pkg::*;
(
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rx_start,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_end,
    input  logic        rx_crc_ok,
    input  logic [3:0]  rx_board,
    output logic        reg_wen,
    output logic [15:0] reg_waddr,
    output logic [31:0] reg_wdata,
    output logic [15:0] hub_seq,
    output logic [15:0] hub_upd_mask,
    output logic        hub_ovf,
    input  logic        hub_ovf_clr
);

    logic [2:0]        state_q, state_d;
    logic [3:0]        board_q, board_d;
    logic [15:0]       hdr_seq_q, hdr_seq_d;
    logic [QIDX_W-1:0] qidx_q, qidx_d;
    logic              crc_ok_q, crc_ok_d;
    logic              wen_q, wen_d;
    logic [15:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              ovf_set;
    logic              commit;
    logic              abort;
    logic              restart;

`ifdef HUB_TIMESTAMP_EN
    localparam logic [QIDX_W-1:0] QIDX_TS = QIDX_W'(SLOT_QUADS - 1);
    logic [31:0] ts_cnt_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) ts_cnt_q <= 32'd0;
        else        ts_cnt_q <= ts_cnt_q + 32'd1;
    end
`endif

    assign restart = rx_start & rx_valid;

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        hdr_seq_d = hdr_seq_q;
        qidx_d    = qidx_q;
        crc_ok_d  = crc_ok_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        ovf_set   = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (qidx_q == QIDX_MAX) begin
                        ovf_set = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        wen_d   = 1'b1;
                        waddr_d = hub_addr(board_q, qidx_q);
                        wdata_d = rx_data;
                        qidx_d  = qidx_q + 1'b1;
                    end
                end
                if (rx_end) begin
                    crc_ok_d = rx_crc_ok;
                    state_d  = ST_COMMIT;
                end
            end
            ST_DROP: begin
                if (rx_end) begin
                    crc_ok_d = rx_crc_ok;
                    state_d  = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
`ifdef HUB_TIMESTAMP_EN
                if (crc_ok_q) begin
                    wen_d   = 1'b1;
                    waddr_d = hub_addr(board_q, QIDX_TS);
                    wdata_d = ts_cnt_q;
                    state_d = ST_TSTAMP;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
`else
                commit  = 1'b1;
                state_d = ST_IDLE;
`endif
            end
`ifdef HUB_TIMESTAMP_EN
            ST_TSTAMP: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A header quadlet always wins: any packet still in flight is abandoned uncommitted.
        if (restart) begin
            abort     = (state_q != ST_IDLE);
            commit    = 1'b0;
            ovf_set   = 1'b0;
            wen_d     = 1'b0;
            waddr_d   = waddr_q;
            wdata_d   = wdata_q;
            board_d   = rx_board;
            hdr_seq_d = rx_data[15:0];
            qidx_d    = '0;
            state_d   = ST_PAYLOAD;
        end

        ovf_d = ovf_set | (ovf_q & ~hub_ovf_clr);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            board_q   <= 4'd0;
            hdr_seq_q <= 16'd0;
            qidx_q    <= '0;
            crc_ok_q  <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= 16'd0;
            wdata_q   <= 32'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            hdr_seq_q <= hdr_seq_d;
            qidx_q    <= qidx_d;
            crc_ok_q  <= crc_ok_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ovf_q     <= ovf_d;
        end
    end

    hub_write_ctrl_seq_tracker u_seq_tracker (
        .sysclk         (sysclk),
        .reset          (reset),
        .commit_i       (commit),
        .abort_i        (abort),
        .crc_ok_i       (crc_ok_q),
        .board_i        (board_q),
        .seq_i          (hdr_seq_q),
        .hub_seq_o      (hub_seq),
        .hub_upd_mask_o (hub_upd_mask)
    );

    assign reg_wen   = wen_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;
    assign hub_ovf   = ovf_q;

endmodule

// File: tb/tb_hub_write_ctrl.sv
// Directed and randomized broadcast packets checked against a packet-level model of hub writes and sequence state.
module tb_hub_write_ctrl;
    import hub_write_ctrl_pkg::*;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_end = 1'b0;
    logic        rx_crc_ok = 1'b0;
    logic        hub_ovf_clr = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic [3:0]  rx_board = 4'd0;
    logic        reg_wen;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic [15:0] hub_seq;
    logic [15:0] hub_upd_mask;
    logic        hub_ovf;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_seq = 16'd0;
    logic [15:0] m_mask = 16'd0;
    logic        m_ovf = 1'b0;
    int          pend_board = -1;
    logic [31:0] ts_cnt;

    always #5 sysclk = ~sysclk;

    // Free-running reference time base (same reset as the design's optional timestamp counter).
    always @(posedge sysclk or negedge reset) begin
        if (!reset) ts_cnt <= 32'd0;
        else        ts_cnt <= ts_cnt + 32'd1;
    end

    hub_write_ctrl dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .rx_start     (rx_start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_end       (rx_end),
        .rx_crc_ok    (rx_crc_ok),
        .rx_board     (rx_board),
        .reg_wen      (reg_wen),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .hub_seq      (hub_seq),
        .hub_upd_mask (hub_upd_mask),
        .hub_ovf      (hub_ovf),
        .hub_ovf_clr  (hub_ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of receive inputs, then check the registered write port one cycle later.
    task automatic cyc(input logic s, input logic v, input logic e, input logic c,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic ew, input logic [15:0] ea, input logic [31:0] ed);
        rx_start  = s;
        rx_valid  = v;
        rx_end    = e;
        rx_crc_ok = c;
        rx_data   = d;
        rx_board  = b;
        @(negedge sysclk);
        chk("reg_wen", {31'd0, reg_wen}, {31'd0, ew});
        if (ew) begin
            chk("reg_waddr", {16'd0, reg_waddr}, {16'd0, ea});
            chk("reg_wdata", reg_wdata, ed);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_seq"}, {16'd0, hub_seq}, {16'd0, m_seq});
        chk({tag, "_mask"}, {16'd0, hub_upd_mask}, {16'd0, m_mask});
        chk({tag, "_ovf"}, {31'd0, hub_ovf}, {31'd0, m_ovf});
    endtask

    task automatic packet(input logic [3:0] b, input logic [15:0] seq, input int n, input logic crc,
                          input logic end_last, input int gap_pct, input int stop_after,
                          input logic clr_at_ovf);
        logic [31:0] d;
        logic        ew;
        logic        last;
        if (pend_board >= 0) begin
            m_mask[pend_board] = 1'b0;
            pend_board = -1;
        end
        d = {16'($urandom), seq};
        cyc(1'b1, 1'b1, 1'b0, 1'b0, d, b, 1'b0, 16'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (stop_after == i) begin
                pend_board = int'(b);
                $display("pkt board=%0d seq=%h left open after %0d quadlets", b, seq, i);
                return;
            end
            while ($urandom_range(99) < gap_pct)
                cyc(1'b0, 1'b0, 1'b0, 1'b0, $urandom, b, 1'b0, 16'd0, 32'd0);
            d    = $urandom;
            last = (i == n - 1) && end_last;
            ew   = (i < MAX_PAYLOAD);
            if (!ew) m_ovf = 1'b1;
            hub_ovf_clr = clr_at_ovf && (i == MAX_PAYLOAD);
            cyc(1'b0, 1'b1, last, crc, d, b, ew, {ADDR_HUB, 3'b000, b, 5'(i)}, d);
            hub_ovf_clr = 1'b0;
        end
        if (!end_last || n == 0)
            cyc(1'b0, 1'b0, 1'b1, crc, $urandom, b, 1'b0, 16'd0, 32'd0);
`ifdef HUB_TIMESTAMP_EN
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, b, crc, {ADDR_HUB, 3'b000, b, 5'd31}, ts_cnt);
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, b, 1'b0, 16'd0, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, b, 1'b0, 16'd0, 32'd0);
        if (crc) begin
            if (seq != m_seq) begin
                m_seq  = seq;
                m_mask = 16'd1 << b;
            end else begin
                m_mask[b] = 1'b1;
            end
        end else begin
            m_mask[b] = 1'b0;
        end
        check_state("pkt");
        $display("pkt board=%0d seq=%h n=%0d crc=%0b -> hub_seq=%h mask=%h ovf=%0b",
                 b, seq, n, crc, hub_seq, hub_upd_mask, hub_ovf);
    endtask

    task automatic clear_ovf();
        hub_ovf_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 16'd0, 32'd0);
        hub_ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_clr", {31'd0, hub_ovf}, 32'd0);
        $display("ovf clear -> hub_ovf=%0b", hub_ovf);
    endtask

    initial begin
        logic [3:0]  rb;
        logic [15:0] rs;
        logic [31:0] d;
        int          rn;
        int          stop;

        repeat (3) @(negedge sysclk);
        chk("rst_wen", {31'd0, reg_wen}, 32'd0);
        chk("rst_waddr", {16'd0, reg_waddr}, 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        check_state("rst");
        reset = 1'b1;
        @(negedge sysclk);

        packet(4'd3, 16'h0010, 4, 1'b1, 1'b1, 0, -1, 1'b0);
        packet(4'd5, 16'h0010, 3, 1'b1, 1'b0, 0, -1, 1'b0);
        packet(4'd5, 16'h0011, 3, 1'b1, 1'b1, 0, -1, 1'b0);
        packet(4'd2, 16'h0011, 30, 1'b1, 1'b1, 0, -1, 1'b1);
        clear_ovf();
        packet(4'd7, 16'h0011, 2, 1'b1, 1'b1, 0, -1, 1'b0);
        packet(4'd7, 16'h0011, 5, 1'b0, 1'b1, 0, -1, 1'b0);
        packet(4'd4, 16'h0011, 5, 1'b1, 1'b1, 0, -1, 1'b0);
        packet(4'd4, 16'h0011, 10, 1'b1, 1'b1, 0, 5, 1'b0);
        packet(4'd1, 16'h0011, 6, 1'b1, 1'b1, 0, -1, 1'b0);
        packet(4'd9, 16'h0011, 0, 1'b1, 1'b1, 0, -1, 1'b0);
        packet(4'd12, 16'h0011, 28, 1'b1, 1'b1, 0, -1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            rb   = 4'($urandom_range(15));
            rs   = m_seq + 16'($urandom_range(1));
            rn   = int'($urandom_range(31));
            stop = ($urandom_range(3) == 0) ? int'($urandom_range(30)) : -1;
            packet(rb, rs, rn, ($urandom_range(9) != 0), 1'($urandom_range(1)), 20, stop, 1'b0);
            if (m_ovf && $urandom_range(1) == 0) clear_ovf();
        end

        // Reset in the middle of a packet: write port drops at once and nothing commits.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0050, 4'd6, 1'b0, 16'd0, 32'd0);
        d = $urandom;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, d, 4'd6, 1'b1, {ADDR_HUB, 3'b000, 4'd6, 5'd0}, d);
        reset = 1'b0;
        #1;
        m_seq = 16'd0;
        m_mask = 16'd0;
        m_ovf = 1'b0;
        pend_board = -1;
        chk("midrst_wen", {31'd0, reg_wen}, 32'd0);
        check_state("midrst");
        rx_start = 1'b0;
        rx_valid = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, $urandom, 4'd6, 1'b0, 16'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd6, 1'b0, 16'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd6, 1'b0, 16'd0, 32'd0);
        check_state("postrst");
        $display("reset mid-packet -> hub_seq=%h mask=%h", hub_seq, hub_upd_mask);
        packet(4'd0, 16'h0022, 3, 1'b1, 1'b1, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
